alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer: feeds a registered ALU from a 16x32 register file
// and writes the result back. Optional opcode check: OPCHECK_EN.
module alu_operand_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [3:0]  cmd_ra,
   input  logic [3:0]  cmd_rb,
   input  logic [3:0]  cmd_rd,
   output logic [31:0] X,
   output logic [31:0] Y,
   output logic [3:0]  S,
   input  logic [31:0] r,
   input  logic        Zflag,
   input  logic        ld_en,
   input  logic [3:0]  ld_addr,
   input  logic [31:0] ld_data,
   input  logic [3:0]  rb_addr,
   output logic [31:0] rb_data,
   output logic        done,
   output logic        z_q,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_rf [16];
   logic [31:0] r_x;
   logic [31:0] r_y;
   logic [3:0]  r_s;
   logic [3:0]  r_rd;
   logic        r_done;
   logic        r_zq;
   logic        w_ready;
   logic        w_busy;
   logic        w_accept;
   logic        w_go;
   logic        w_ld_we;
   logic        w_wb_we;

`ifdef OPCHECK_EN
   logic        w_legal;
   logic        r_err;

   // Decode the opcodes the ALU actually implements
   always_comb begin
      w_legal = 1'b0;
      case (cmd_op)
         4'd0, 4'd1, 4'd2,
         4'd6, 4'd7, 4'd12: w_legal = 1'b1;
         default:           w_legal = 1'b0;
      endcase
   end

   assign w_go = w_accept & w_legal;

   // Illegal opcodes are consumed and flagged for one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_accept & ~w_legal;
   end

   assign err = r_err;
`else
   assign w_go = w_accept;
   assign err  = 1'b0;
`endif

   assign w_accept = cmd_valid & w_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state: one accept walks IDLE -> WAIT -> WB -> IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_go) w_next = ST_WAIT;
         ST_WAIT: w_next = ST_WB;
         ST_WB:   w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM outputs; a load in IDLE blocks command acceptance
   always_comb begin
      w_ready = (r_state == ST_IDLE) & ~ld_en;
      w_busy  = (r_state != ST_IDLE);
      w_ld_we = (r_state == ST_IDLE) & ld_en;
      w_wb_we = (r_state == ST_WB);
   end

   // Register file: preload in IDLE, ALU result written back from WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) r_rf[i] <= '0;
      end else if (w_wb_we) begin
         r_rf[r_rd] <= r;
      end else if (w_ld_we) begin
         r_rf[ld_addr] <= ld_data;
      end
   end

   // Operand/select drivers held until the next accepted command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x  <= '0;
         r_y  <= '0;
         r_s  <= '0;
         r_rd <= '0;
      end else if (w_go) begin
         r_x  <= r_rf[cmd_ra];
         r_y  <= r_rf[cmd_rb];
         r_s  <= cmd_op;
         r_rd <= cmd_rd;
      end
   end

   // Completion pulse and captured zero flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_zq   <= 1'b0;
      end else begin
         r_done <= w_wb_we;
         if (w_wb_we) r_zq <= Zflag;
      end
   end

   assign cmd_ready = w_ready;
   assign busy      = w_busy;
   assign X         = r_x;
   assign Y         = r_y;
   assign S         = r_s;
   assign done      = r_done;
   assign z_q       = r_zq;
   assign rb_data   = r_rf[rb_addr];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a registered ALU
// model; OPCHECK_EN selects the illegal-opcode expectations.
module tb_alu_operand_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op, cmd_ra, cmd_rb, cmd_rd;
   logic [31:0] X, Y;
   logic [3:0]  S;
   logic [31:0] r;
   logic        Zflag;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  rb_addr;
   logic [31:0] rb_data;
   logic        done, z_q, busy, err;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  s;
      logic        z;
      int          t;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   alu_operand_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_ra(cmd_ra),
      .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
      .X(X), .Y(Y), .S(S), .r(r), .Zflag(Zflag),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rb_addr(rb_addr), .rb_data(rb_data),
      .done(done), .z_q(z_q), .busy(busy), .err(err)
   );

   function automatic logic [31:0] alu_f(
      input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      case (s)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return {31'd0, $signed(a) < $signed(b)};
         4'd12:   return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   // Registered ALU: result one edge after X/Y/S
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r     <= '0;
         Zflag <= 1'b0;
      end else begin
         r     <= alu_f(X, Y, S);
         Zflag <= (alu_f(X, Y, S) == 32'd0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_checks++;
      n_err++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   // Monitor: every done pulse must match the oldest expected op
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            fail("unexpected_done");
         end else begin
            mon_e = q.pop_front();
            chk("done_cycle", cyc, mon_e.t);
            chk("z_q", {31'd0, z_q}, {31'd0, mon_e.z});
            chk("X_at_done", X, mon_e.x);
            chk("Y_at_done", Y, mon_e.y);
            chk("S_at_done", {28'd0, S}, {28'd0, mon_e.s});
         end
      end
   end

   task automatic load(input logic [3:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic rdchk(input string nm, input logic [3:0] a,
                        input logic [31:0] e);
      rb_addr = a;
      #1;
      chk(nm, rb_data, e);
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rd,
                        input logic [31:0] ex, input logic [31:0] ey,
                        input logic ez, input bit keep, input bit push,
                        output int t);
      int n;
      cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
      cmd_valid = 1'b1;
      #1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      if (n >= 20) fail("issue_timeout");
      else if (push) q.push_back('{ex, ey, op, ez, cyc + 3});
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (k >= 10) begin
         fail(nm);
      end else begin
         @(negedge clk);
         chk({nm, "_single"}, {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1;
      rst_n = 1'b0; cmd_valid = 1'b0;
      cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; rb_addr = '0;
      repeat (2) @(negedge clk);
      chk("rst_X", X, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

      // ADD 5+3 into r3
      load(4'd1, 32'd5);
      load(4'd2, 32'd3);
      issue(4'd2, 4'd1, 4'd2, 4'd3, 32'd5, 32'd3, 1'b0, 0, 1, t0);
      chk("e0_X", X, 32'd5);
      chk("e0_Y", Y, 32'd3);
      chk("e0_S", {28'd0, S}, 32'd2);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      chk("wait_ready", {31'd0, cmd_ready}, 32'd0);
      wait_done("add_done");
      rdchk("rf3_add", 4'd3, 32'd8);

      // SUB r4-r4 into r4: zero result
      load(4'd4, 32'd7);
      issue(4'd6, 4'd4, 4'd4, 4'd4, 32'd7, 32'd7, 1'b1, 0, 1, t0);
      wait_done("sub_done");
      rdchk("rf4_sub", 4'd4, 32'd0);

      // Back-to-back AND then OR with cmd_valid held
      issue(4'd0, 4'd1, 4'd2, 4'd5, 32'd5, 32'd3, 1'b0, 1, 1, t0);
      chk("b2b_ready_wait", {31'd0, cmd_ready}, 32'd0);
      issue(4'd1, 4'd1, 4'd2, 4'd6, 32'd5, 32'd3, 1'b0, 0, 1, t1);
      chk("b2b_spacing", t1 - t0, 32'd3);
      wait_done("or_done");
      rdchk("rf5_and", 4'd5, 32'd1);
      rdchk("rf6_or", 4'd6, 32'd7);

      // Load beats command in IDLE
      ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'h1234_5678;
      cmd_op = 4'd2; cmd_ra = 4'd1; cmd_rb = 4'd2; cmd_rd = 4'd9;
      cmd_valid = 1'b1;
      #1;
      chk("ld_prio_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      ld_en = 1'b0; cmd_valid = 1'b0;
      #1;
      chk("ld_prio_busy", {31'd0, busy}, 32'd0);
      rdchk("rf7_load", 4'd7, 32'h1234_5678);

      // Load during WAIT ignored
      issue(4'd0, 4'd7, 4'd7, 4'd8, 32'h1234_5678, 32'h1234_5678,
            1'b0, 0, 1, t0);
      ld_en = 1'b1; ld_addr = 4'd9; ld_data = 32'hDEAD_BEEF;
      @(negedge clk);
      ld_en = 1'b0;
      wait_done("and2_done");
      rdchk("ld_busy_ignored", 4'd9, 32'd0);
      rdchk("rf8_and", 4'd8, 32'h1234_5678);

      // Reset while in WAIT aborts the command
      issue(4'd2, 4'd1, 4'd2, 4'd10, 32'd0, 32'd0, 1'b0, 0, 0, t0);
      rst_n = 1'b0;
      #1;
      chk("abort_X", X, 32'd0);
      chk("abort_Y", Y, 32'd0);
      chk("abort_S", {28'd0, S}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd0);
      chk("abort_zq", {31'd0, z_q}, 32'd0);
      rdchk("abort_rf1", 4'd1, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (4) @(negedge clk);
      rdchk("abort_rf10", 4'd10, 32'd0);

      // SLT and NOR
      load(4'd1, 32'd5);
      load(4'd2, 32'd3);
      issue(4'd7, 4'd2, 4'd1, 4'd13, 32'd3, 32'd5, 1'b0, 0, 1, t0);
      wait_done("slt_done");
      rdchk("rf13_slt", 4'd13, 32'd1);
      issue(4'd12, 4'd1, 4'd2, 4'd14, 32'd5, 32'd3, 1'b0, 0, 1, t0);
      wait_done("nor_done");
      rdchk("rf14_nor", 4'd14, 32'hFFFF_FFF8);

      // Opcode 3
`ifdef OPCHECK_EN
      cmd_op = 4'd3; cmd_ra = 4'd2; cmd_rb = 4'd1; cmd_rd = 4'd15;
      cmd_valid = 1'b1;
      #1;
      chk("ill_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ill_err", {31'd0, err}, 32'd1);
      chk("ill_busy", {31'd0, busy}, 32'd0);
      chk("ill_X", X, 32'd5);
      chk("ill_Y", Y, 32'd3);
      chk("ill_S", {28'd0, S}, 32'd12);
      @(negedge clk);
      chk("ill_err_clr", {31'd0, err}, 32'd0);
      chk("ill_busy2", {31'd0, busy}, 32'd0);
      rdchk("ill_rf15", 4'd15, 32'd0);
`else
      issue(4'd3, 4'd2, 4'd1, 4'd15, 32'd3, 32'd5, 1'b0, 0, 1, t0);
      chk("op3_S", {28'd0, S}, 32'd3);
      chk("op3_err", {31'd0, err}, 32'd0);
      wait_done("op3_done");
      rdchk("rf15_op3", 4'd15, 32'd6);
`endif

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
